thread_select_stage: RTL and testbench

Issue stage directly upstream of operand fetch. Buffers decoded instructions in per-thread FIFOs and tracks pending destination registers with a per-thread scoreboard. Each cycle it picks one ready thread round-robin and issues that thread's head instruction, one subcycle at a time, on the `ts_*` bus. Applies back-pressure to decode and flushes a thread's state on rollback.

---
 rtl/thread_select_stage_pkg.sv | 51 +++++
 rtl/thread_select_stage_instruction_fifo.sv | 59 +++++
 rtl/thread_select_stage.sv | 186 ++++++++++++++++++
 tb/tb_thread_select_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_select_stage_pkg.sv
// Shared types and constants for the thread select (issue) stage.
package thread_select_stage_pkg;

  localparam int CORE_THREADS = 4;
  localparam int FETCH_SLACK  = 2;

  typedef logic [$clog2(CORE_THREADS)-1:0] thread_idx_t;
  typedef logic [3:0]                      subcycle_t;
  typedef logic [4:0]                      register_idx_t;
  typedef logic [63:0]                     scoreboard_t;

  typedef struct packed {
    logic [31:0]   pc;
    logic          has_scalar1;
    register_idx_t scalar_sel1;
    logic          has_scalar2;
    register_idx_t scalar_sel2;
    logic          has_vector1;
    register_idx_t vector_sel1;
    logic          has_vector2;
    register_idx_t vector_sel2;
    logic          has_dest;
    logic          dest_is_vector;
    register_idx_t dest_reg;
    subcycle_t     last_subcycle;
  } decoded_instruction_t;

  // One entry per issue slot; lets a rollback undo the scoreboard bits it set.
  typedef struct packed {
    logic          valid;
    thread_idx_t   thread;
    logic          has_dest;
    logic          is_vector;
    register_idx_t dest_reg;
    logic          first_subcycle;
  } shadow_entry_t;

  // Scoreboard bits an instruction depends on: its sources (RAW) and its
  // destination (WAW). Scalars live in [31:0], vectors in [63:32].
  function automatic scoreboard_t dep_mask(input decoded_instruction_t inst);
    scoreboard_t m;
    m = '0;
    if (inst.has_scalar1) m[{1'b0, inst.scalar_sel1}] = 1'b1;
    if (inst.has_scalar2) m[{1'b0, inst.scalar_sel2}] = 1'b1;
    if (inst.has_vector1) m[{1'b1, inst.vector_sel1}] = 1'b1;
    if (inst.has_vector2) m[{1'b1, inst.vector_sel2}] = 1'b1;
    if (inst.has_dest)    m[{inst.dest_is_vector, inst.dest_reg}] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/thread_select_stage_instruction_fifo.sv
// Per-thread synchronous instruction FIFO with flush; head is read combinationally.
module instruction_fifo
  import thread_select_stage_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  decoded_instruction_t   i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output decoded_instruction_t   o_head,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  decoded_instruction_t r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  // Flush wins over a same-cycle push or pop; a push into a full FIFO is dropped.
  assign w_do_push = i_push && !i_flush && !o_full;
  assign w_do_pop  = i_pop && !i_flush && !o_empty;
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_flush && o_full))
    else $error("instruction_fifo: push into full FIFO dropped");

endmodule

// File: rtl/thread_select_stage.sv
// Issue stage: per-thread FIFOs, scoreboards, round-robin pick, rollback shadow.
module thread_select_stage
  import thread_select_stage_pkg::*;
#(
  parameter int THREADS_PER_CORE = CORE_THREADS,
  parameter int FIFO_DEPTH       = 8,
  parameter int ROLLBACK_STAGES  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        id_instruction_valid,
  input  decoded_instruction_t        id_instruction,
  input  thread_idx_t                 id_thread_idx,
  output logic [THREADS_PER_CORE-1:0] ts_fetch_en,
  input  logic [THREADS_PER_CORE-1:0] thread_en,
  output logic                        ts_instruction_valid,
  output decoded_instruction_t        ts_instruction,
  output thread_idx_t                 ts_thread_idx,
  output subcycle_t                   ts_subcycle,
  input  logic                        wb_rollback_en,
  input  thread_idx_t                 wb_rollback_thread_idx,
  input  logic                        wb_writeback_en,
  input  thread_idx_t                 wb_writeback_thread_idx,
  input  logic                        wb_writeback_is_vector,
  input  register_idx_t               wb_writeback_reg,
  input  logic                        wb_writeback_last_subcycle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  decoded_instruction_t        w_head     [THREADS_PER_CORE];
  logic [CNT_W-1:0]            w_count    [THREADS_PER_CORE];
  logic [THREADS_PER_CORE-1:0] w_empty;
  logic [THREADS_PER_CORE-1:0] w_full;
  logic [THREADS_PER_CORE-1:0] w_push;
  logic [THREADS_PER_CORE-1:0] w_pop;
  logic [THREADS_PER_CORE-1:0] w_rollback;
  logic [THREADS_PER_CORE-1:0] w_ready;

  scoreboard_t   r_scoreboard [THREADS_PER_CORE];
  scoreboard_t   w_sb_next    [THREADS_PER_CORE];
  subcycle_t     r_subcycle   [THREADS_PER_CORE];
  shadow_entry_t r_shadow     [ROLLBACK_STAGES];
  shadow_entry_t w_new_entry;
  thread_idx_t   r_rr_ptr;
  thread_idx_t   w_cand;
  logic          w_issue;
  thread_idx_t   w_issue_thread;
  decoded_instruction_t w_issue_inst;
  subcycle_t     w_issue_sub;

  logic                 r_ts_valid;
  decoded_instruction_t r_ts_inst;
  thread_idx_t          r_ts_thread;
  subcycle_t            r_ts_sub;

  for (genvar t = 0; t < THREADS_PER_CORE; t++) begin : g_thread
    assign w_rollback[t] = wb_rollback_en && (wb_rollback_thread_idx == thread_idx_t'(t));
    assign w_push[t]     = id_instruction_valid && (id_thread_idx == thread_idx_t'(t));
    assign w_pop[t]      = w_issue && (w_issue_thread == thread_idx_t'(t))
                           && (r_subcycle[t] == w_head[t].last_subcycle);
    // Dependencies are checked only when an instruction starts; later
    // subcycles of the same instruction must not stall on its own dest bit.
    assign w_ready[t]    = thread_en[t] && !w_empty[t] && !w_rollback[t]
                           && ((r_subcycle[t] != '0)
                               || ((r_scoreboard[t] & dep_mask(w_head[t])) == '0));
    assign ts_fetch_en[t] = (w_count[t] < CNT_W'(FIFO_DEPTH - FETCH_SLACK));

    instruction_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push[t]),
      .i_push_data (id_instruction),
      .i_pop       (w_pop[t]),
      .i_flush     (w_rollback[t]),
      .o_count     (w_count[t]),
      .o_head      (w_head[t]),
      .o_empty     (w_empty[t]),
      .o_full      (w_full[t])
    );
  end

  // Round-robin pick: first ready thread at or after the pointer.
  always_comb begin
    w_issue        = 1'b0;
    w_issue_thread = '0;
    w_cand         = '0;
    for (int k = THREADS_PER_CORE - 1; k >= 0; k--) begin
      w_cand = thread_idx_t'((int'(r_rr_ptr) + k) % THREADS_PER_CORE);
      if (w_ready[w_cand]) begin
        w_issue        = 1'b1;
        w_issue_thread = w_cand;
      end
    end
    w_issue_inst = w_head[w_issue_thread];
    w_issue_sub  = r_subcycle[w_issue_thread];
  end

  // Next scoreboard: writeback clear, rollback undo, then issue set (set wins).
  always_comb begin
    for (int t = 0; t < THREADS_PER_CORE; t++) begin
      w_sb_next[t] = r_scoreboard[t];
      if (wb_writeback_en && wb_writeback_last_subcycle
          && (wb_writeback_thread_idx == thread_idx_t'(t)))
        w_sb_next[t][{wb_writeback_is_vector, wb_writeback_reg}] = 1'b0;
      for (int s = 0; s < ROLLBACK_STAGES; s++) begin
        if (w_rollback[t] && r_shadow[s].valid && (r_shadow[s].thread == thread_idx_t'(t))
            && r_shadow[s].has_dest && r_shadow[s].first_subcycle)
          w_sb_next[t][{r_shadow[s].is_vector, r_shadow[s].dest_reg}] = 1'b0;
      end
      if (w_issue && (w_issue_thread == thread_idx_t'(t)) && (r_subcycle[t] == '0)
          && w_head[t].has_dest)
        w_sb_next[t][{w_head[t].dest_is_vector, w_head[t].dest_reg}] = 1'b1;
    end
  end

  always_comb begin
    w_new_entry.valid          = w_issue;
    w_new_entry.thread         = w_issue_thread;
    w_new_entry.has_dest       = w_issue_inst.has_dest;
    w_new_entry.is_vector      = w_issue_inst.dest_is_vector;
    w_new_entry.dest_reg       = w_issue_inst.dest_reg;
    w_new_entry.first_subcycle = (w_issue_sub == '0);
  end

  // Scoreboard and subcycle counters.
  always_ff @(posedge clk) begin
    for (int t = 0; t < THREADS_PER_CORE; t++) begin
      if (reset) begin
        r_scoreboard[t] <= '0;
        r_subcycle[t]   <= '0;
      end else begin
        r_scoreboard[t] <= w_sb_next[t];
        if (w_rollback[t])
          r_subcycle[t] <= '0;
        else if (w_issue && (w_issue_thread == thread_idx_t'(t)))
          r_subcycle[t] <= w_pop[t] ? '0 : r_subcycle[t] + 1'b1;
      end
    end
  end

  // In-flight shadow: shift every cycle, drop entries of a rolled-back thread.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < ROLLBACK_STAGES; s++) r_shadow[s] <= '0;
    end else begin
      r_shadow[0] <= w_new_entry;
      for (int s = 1; s < ROLLBACK_STAGES; s++) begin
        r_shadow[s] <= r_shadow[s-1];
        if (wb_rollback_en && (r_shadow[s-1].thread == wb_rollback_thread_idx))
          r_shadow[s].valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer moves past the issuing thread.
  always_ff @(posedge clk) begin
    if (reset)
      r_rr_ptr <= '0;
    else if (w_issue)
      r_rr_ptr <= (int'(w_issue_thread) == THREADS_PER_CORE - 1) ? '0 : w_issue_thread + 1'b1;
  end

  // Registered issue bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts_valid  <= 1'b0;
      r_ts_inst   <= '0;
      r_ts_thread <= '0;
      r_ts_sub    <= '0;
    end else begin
      r_ts_valid <= w_issue;
      if (w_issue) begin
        r_ts_inst   <= w_issue_inst;
        r_ts_thread <= w_issue_thread;
        r_ts_sub    <= w_issue_sub;
      end
    end
  end

  assign ts_instruction_valid = r_ts_valid;
  assign ts_instruction       = r_ts_inst;
  assign ts_thread_idx        = r_ts_thread;
  assign ts_subcycle          = r_ts_sub;

endmodule

// File: tb/tb_thread_select_stage.sv
// Bench for thread_select_stage: directed scenarios plus random traffic, all
// checked against a queue-based model of the issue rules.
module tb_thread_select_stage;
  import thread_select_stage_pkg::*;

  localparam int T     = 4;
  localparam int DEPTH = 8;
  localparam int RS    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 id_instruction_valid;
  decoded_instruction_t id_instruction;
  thread_idx_t          id_thread_idx;
  logic [T-1:0]         ts_fetch_en;
  logic [T-1:0]         thread_en;
  logic                 ts_instruction_valid;
  decoded_instruction_t ts_instruction;
  thread_idx_t          ts_thread_idx;
  subcycle_t            ts_subcycle;
  logic                 wb_rollback_en;
  thread_idx_t          wb_rollback_thread_idx;
  logic                 wb_writeback_en;
  thread_idx_t          wb_writeback_thread_idx;
  logic                 wb_writeback_is_vector;
  register_idx_t        wb_writeback_reg;
  logic                 wb_writeback_last_subcycle;

  thread_select_stage #(.THREADS_PER_CORE(T), .FIFO_DEPTH(DEPTH), .ROLLBACK_STAGES(RS)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .id_instruction_valid       (id_instruction_valid),
    .id_instruction             (id_instruction),
    .id_thread_idx              (id_thread_idx),
    .ts_fetch_en                (ts_fetch_en),
    .thread_en                  (thread_en),
    .ts_instruction_valid       (ts_instruction_valid),
    .ts_instruction             (ts_instruction),
    .ts_thread_idx              (ts_thread_idx),
    .ts_subcycle                (ts_subcycle),
    .wb_rollback_en             (wb_rollback_en),
    .wb_rollback_thread_idx     (wb_rollback_thread_idx),
    .wb_writeback_en            (wb_writeback_en),
    .wb_writeback_thread_idx    (wb_writeback_thread_idx),
    .wb_writeback_is_vector     (wb_writeback_is_vector),
    .wb_writeback_reg           (wb_writeback_reg),
    .wb_writeback_last_subcycle (wb_writeback_last_subcycle)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: FIFOs as queues, scoreboards as bit arrays, and the
  // last RS issue slots as a list of "which bit did this slot set".
  typedef struct {
    bit v;
    int thr;
    bit sets;
    int bit_idx;
  } slot_t;

  decoded_instruction_t mq [T][$];
  int                   msub [T];
  logic [63:0]          msb [T];
  int                   mrr;
  slot_t                mslots [$];
  bit                   exp_valid;
  int                   exp_thr;
  int                   exp_sub;
  logic [31:0]          exp_pc;
  int                   issue_log [$];
  int                   next_pc = 1000;

  function automatic int dest_bit(input decoded_instruction_t i);
    return (i.dest_is_vector ? 32 : 0) + int'(i.dest_reg);
  endfunction

  function automatic bit m_ready(input int t, input int rb);
    decoded_instruction_t h;
    logic [63:0] b;
    if (!thread_en[t] || mq[t].size() == 0 || rb == t) return 1'b0;
    if (msub[t] != 0) return 1'b1;
    h = mq[t][0];
    b = msb[t];
    if (h.has_scalar1 && b[int'(h.scalar_sel1)]) return 1'b0;
    if (h.has_scalar2 && b[int'(h.scalar_sel2)]) return 1'b0;
    if (h.has_vector1 && b[32 + int'(h.vector_sel1)]) return 1'b0;
    if (h.has_vector2 && b[32 + int'(h.vector_sel2)]) return 1'b0;
    if (h.has_dest && b[dest_bit(h)]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < T; t++) begin
      mq[t].delete();
      msub[t] = 0;
      msb[t]  = '0;
    end
    mrr = 0;
    mslots.delete();
    exp_valid = 1'b0;
  endtask

  task automatic model_step();
    int rb, sel, idt;
    bit push_ok;
    slot_t e;
    decoded_instruction_t h;
    rb  = wb_rollback_en ? int'(wb_rollback_thread_idx) : -1;
    idt = int'(id_thread_idx);
    push_ok = mq[idt].size() < DEPTH;
    sel = -1;
    for (int k = 0; k < T; k++)
      if (sel < 0 && m_ready((mrr + k) % T, rb)) sel = (mrr + k) % T;
    if (wb_writeback_en && wb_writeback_last_subcycle)
      msb[int'(wb_writeback_thread_idx)][(wb_writeback_is_vector ? 32 : 0) + int'(wb_writeback_reg)] = 1'b0;
    if (rb >= 0)
      foreach (mslots[i])
        if (mslots[i].v && mslots[i].thr == rb) begin
          if (mslots[i].sets) msb[rb][mslots[i].bit_idx] = 1'b0;
          mslots[i].v = 1'b0;
        end
    e = '{v: 1'b0, thr: 0, sets: 1'b0, bit_idx: 0};
    exp_valid = (sel >= 0);
    if (sel >= 0) begin
      h = mq[sel][0];
      exp_thr = sel;
      exp_sub = msub[sel];
      exp_pc  = h.pc;
      e = '{v: 1'b1, thr: sel, sets: (msub[sel] == 0) && h.has_dest, bit_idx: dest_bit(h)};
      if (e.sets) msb[sel][e.bit_idx] = 1'b1;
      if (msub[sel] == int'(h.last_subcycle)) begin
        void'(mq[sel].pop_front());
        msub[sel] = 0;
      end else begin
        msub[sel]++;
      end
      mrr = (sel + 1) % T;
    end
    mslots.push_front(e);
    if (mslots.size() > RS) void'(mslots.pop_back());
    if (rb >= 0) begin
      mq[rb].delete();
      msub[rb] = 0;
    end
    if (id_instruction_valid && idt != rb && push_ok) mq[idt].push_back(id_instruction);
  endtask

  // One clock: compare registered outputs, advance the model, clear pulses.
  task automatic cycle();
    check_val("ts_valid", 64'(ts_instruction_valid), 64'(exp_valid));
    if (exp_valid) begin
      check_val("ts_thread", 64'(ts_thread_idx), 64'(exp_thr));
      check_val("ts_subcycle", 64'(ts_subcycle), 64'(exp_sub));
      check_val("ts_pc", 64'(ts_instruction.pc), 64'(exp_pc));
    end
    for (int t = 0; t < T; t++)
      check_val("fetch_en", 64'(ts_fetch_en[t]), 64'(mq[t].size() < DEPTH - FETCH_SLACK));
    if (ts_instruction_valid) issue_log.push_back(int'(ts_thread_idx));
    if (reset) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    id_instruction_valid = 1'b0;
    wb_writeback_en      = 1'b0;
    wb_rollback_en       = 1'b0;
  endtask

  task automatic do_reset();
    id_instruction_valid = 1'b0;
    wb_writeback_en      = 1'b0;
    wb_rollback_en       = 1'b0;
    thread_en            = '1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    issue_log.delete();
    check_val("reset_valid", 64'(ts_instruction_valid), 64'd0);
    check_val("reset_thread", 64'(ts_thread_idx), 64'd0);
    check_val("reset_subcycle", 64'(ts_subcycle), 64'd0);
    check_val("reset_fetch_en", 64'(ts_fetch_en), 64'hF);
  endtask

  function automatic decoded_instruction_t mk(input int pc, input bit hs1, input int s1,
                                              input bit hs2, input int s2, input bit hd,
                                              input bit dv, input int d, input int last);
    decoded_instruction_t i;
    i = '0;
    i.pc = 32'(pc);
    i.has_scalar1 = hs1;  i.scalar_sel1 = register_idx_t'(s1);
    i.has_scalar2 = hs2;  i.scalar_sel2 = register_idx_t'(s2);
    i.has_dest = hd;      i.dest_is_vector = dv;  i.dest_reg = register_idx_t'(d);
    i.last_subcycle = subcycle_t'(last);
    return i;
  endfunction

  function automatic decoded_instruction_t rand_inst();
    decoded_instruction_t i;
    i = '0;
    i.pc = 32'(next_pc);
    next_pc++;
    i.has_scalar1 = 1'($urandom_range(0, 1)); i.scalar_sel1 = register_idx_t'($urandom_range(0, 7));
    i.has_scalar2 = 1'($urandom_range(0, 1)); i.scalar_sel2 = register_idx_t'($urandom_range(0, 7));
    i.has_vector1 = 1'($urandom_range(0, 1)); i.vector_sel1 = register_idx_t'($urandom_range(0, 7));
    i.has_vector2 = 1'($urandom_range(0, 1)); i.vector_sel2 = register_idx_t'($urandom_range(0, 7));
    i.has_dest = 1'($urandom_range(0, 1));
    i.dest_is_vector = 1'($urandom_range(0, 1));
    i.dest_reg = register_idx_t'($urandom_range(0, 7));
    i.last_subcycle = ($urandom_range(0, 5) == 0) ? subcycle_t'($urandom_range(1, 3)) : '0;
    return i;
  endfunction

  task automatic push(input int t, input decoded_instruction_t i);
    id_instruction_valid = 1'b1;
    id_thread_idx        = thread_idx_t'(t);
    id_instruction       = i;
  endtask

  task automatic writeback(input int t, input bit vec, input int r, input bit last);
    wb_writeback_en            = 1'b1;
    wb_writeback_thread_idx    = thread_idx_t'(t);
    wb_writeback_is_vector     = vec;
    wb_writeback_reg           = register_idx_t'(r);
    wb_writeback_last_subcycle = last;
  endtask

  function automatic int count_log(input int t);
    int n = 0;
    foreach (issue_log[i]) if (issue_log[i] == t) n++;
    return n;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bits [$];
    id_instruction = '0;
    id_thread_idx = '0;
    wb_rollback_thread_idx = '0;
    wb_writeback_thread_idx = '0;
    wb_writeback_is_vector = 1'b0;
    wb_writeback_reg = '0;
    wb_writeback_last_subcycle = 1'b0;

    // Single issue, then RAW stall on s3 with thread 1 filling the gap.
    do_reset();
    push(0, mk(1, 1, 1, 1, 2, 1, 0, 3, 0));
    cycle();
    check_val("single_n1", 64'(ts_instruction_valid), 64'd0);
    push(0, mk(2, 1, 3, 1, 1, 1, 0, 4, 0));
    cycle();
    check_val("single_valid", 64'(ts_instruction_valid), 64'd1);
    check_val("single_thread", 64'(ts_thread_idx), 64'd0);
    check_val("single_sub", 64'(ts_subcycle), 64'd0);
    push(1, mk(3, 0, 0, 0, 0, 1, 0, 4, 0));
    cycle();
    cycle();
    cycle();
    check_val("raw_stall_t0", 64'(count_log(0)), 64'd1);
    check_val("raw_gap_t1", 64'(count_log(1)), 64'd1);
    writeback(0, 1'b0, 3, 1'b1);
    cycle();
    check_val("raw_wb_next", 64'(ts_instruction_valid), 64'd0);
    cycle();
    check_val("raw_issue_valid", 64'(ts_instruction_valid), 64'd1);
    check_val("raw_issue_pc", 64'(ts_instruction.pc), 64'd2);

    // Round-robin over four threads with two independent entries each.
    do_reset();
    thread_en = '0;
    for (int i = 0; i < 8; i++) begin
      push(i % 4, mk(100 + i, 0, 0, 0, 0, 0, 0, 0, 0));
      cycle();
    end
    thread_en = '1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      check_val("rr_valid", 64'(ts_instruction_valid), 64'd1);
      check_val("rr_thread", 64'(ts_thread_idx), 64'(i % 4));
      cycle();
    end

    // Four-subcycle instruction on thread 2; its dest is set once.
    do_reset();
    push(2, mk(200, 0, 0, 0, 0, 1, 0, 9, 3));
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      check_val("multi_thread", 64'(ts_thread_idx), 64'd2);
      check_val("multi_sub", 64'(ts_subcycle), 64'(i));
      cycle();
    end
    check_val("multi_done", 64'(ts_instruction_valid), 64'd0);
    push(2, mk(201, 1, 9, 0, 0, 0, 0, 0, 0));
    cycle();
    cycle();
    cycle();
    check_val("multi_dep_stall", 64'(ts_instruction_valid), 64'd0);
    writeback(2, 1'b0, 9, 1'b1);
    cycle();
    cycle();
    check_val("multi_dep_issue", 64'(ts_instruction.pc), 64'd201);

    // Back-pressure on a disabled thread.
    do_reset();
    thread_en = 4'b1101;
    for (int i = 0; i < DEPTH - 2; i++) begin
      if (i == DEPTH - 3) check_val("bp_before", 64'(ts_fetch_en), 64'hF);
      push(1, mk(300 + i, 0, 0, 0, 0, 0, 0, 0, 0));
      cycle();
    end
    check_val("bp_fetch_en", 64'(ts_fetch_en), 64'hD);
    thread_en = '1;
    repeat (8) cycle();

    // Rollback of thread 0 while thread 1 runs a multi-subcycle instruction.
    do_reset();
    push(0, mk(400, 0, 0, 0, 0, 1, 0, 5, 0));
    cycle();
    push(0, mk(401, 0, 0, 0, 0, 1, 1, 7, 0));
    cycle();
    push(1, mk(410, 0, 0, 0, 0, 0, 0, 0, 3));
    cycle();
    push(0, mk(402, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    wb_rollback_en = 1'b1;
    wb_rollback_thread_idx = '0;
    push(0, mk(403, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    check_val("rb_t1_continues", 64'(ts_thread_idx), 64'd1);
    check_val("rb_t1_sub", 64'(ts_subcycle), 64'd1);
    issue_log.delete();
    cycle();
    cycle();
    cycle();
    check_val("rb_no_t0", 64'(count_log(0)), 64'd0);
    push(0, mk(404, 1, 5, 0, 0, 1, 1, 7, 0));
    cycle();
    cycle();
    check_val("rb_bits_clear_valid", 64'(ts_instruction_valid), 64'd1);
    check_val("rb_bits_clear_pc", 64'(ts_instruction.pc), 64'd404);

    // Random traffic with writebacks of pending bits, rollbacks and a mid-run reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) thread_en = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        int t = int'($urandom_range(0, T - 1));
        if (mq[t].size() < DEPTH - FETCH_SLACK) push(t, rand_inst());
      end
      if ($urandom_range(0, 2) == 0) begin
        int wt = int'($urandom_range(0, T - 1));
        bits.delete();
        for (int b = 0; b < 64; b++) if (msb[wt][b]) bits.push_back(b);
        if (bits.size() > 0) begin
          int b = bits[$urandom_range(0, bits.size() - 1)];
          writeback(wt, b >= 32, b % 32, $urandom_range(0, 3) != 0);
        end
      end
      if ($urandom_range(0, 24) == 0) begin
        wb_rollback_en = 1'b1;
        wb_rollback_thread_idx = thread_idx_t'($urandom_range(0, T - 1));
      end
      if (c == 1500) reset = 1'b1;
      cycle();
      if (c == 1500) begin
        reset = 1'b0;
        check_val("midreset_valid", 64'(ts_instruction_valid), 64'd0);
        check_val("midreset_fetch_en", 64'(ts_fetch_en), 64'hF);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
